// File: rtl/decode_pipe.sv
// RV32IMF decode stage: GPR/FPR register files with writeback bypass, a
// per-register scoreboard for RAW/WAW interlock, and one registered output stage.
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter bit FP_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             instruction,
  input  logic                    wb_valid,
  input  logic                    wb_fp,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [XLEN-1:0]         out_rs1_data,
  output logic [XLEN-1:0]         out_rs2_data,
  output logic                    out_rd_fp,
  output logic                    out_rd_we,
  output logic [15:0]             stall_cnt
);
  localparam int IW = $clog2(NREG);
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FLW    = 7'b0000111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FSW    = 7'b0100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FP     = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [NREG-1:0][XLEN-1:0] gpr_q, fpr_q;
  logic [NREG-1:0] gpr_pend_q, gpr_pend_d, fpr_pend_q, fpr_pend_d;
  logic [NREG-1:0] gpr_clr_s, fpr_clr_s, gpr_set_s, fpr_set_s, gpr_drop_s, fpr_drop_s;
  logic [NREG-1:0] gpr_busy_s, fpr_busy_s;
  logic            out_valid_q, out_valid_d, out_rd_fp_q, out_rd_fp_d, out_rd_we_q, out_rd_we_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic [15:0]     stall_q, stall_d;

  logic [6:0]      opc_s, f7_s;
  logic [IW-1:0]   rs1_s, rs2_s, rd_s, out_rd_s;
  logic            rs1_use_s, rs2_use_s, rs1_fp_s, rs2_fp_s, rd_fp_s, no_rd_s, rd_we_s;
  logic            byp1_s, byp2_s, haz_s, accept_s;
  logic [XLEN-1:0] rs1_data_s, rs2_data_s;

  assign opc_s    = instruction[6:0];
  assign f7_s     = instruction[31:25];
  assign rd_s     = instruction[7 +: IW];
  assign rs1_s    = instruction[15 +: IW];
  assign rs2_s    = instruction[20 +: IW];
  assign out_rd_s = out_instr_q[7 +: IW];

  // Operand usage and register-file class of sources and destination
  always_comb begin
    rs1_use_s = 1'b0;
    rs2_use_s = 1'b0;
    rs1_fp_s  = 1'b0;
    rs2_fp_s  = 1'b0;
    rd_fp_s   = 1'b0;
    no_rd_s   = 1'b0;
    case (opc_s)
      OPC_LOAD, OPC_IMM, OPC_JALR: rs1_use_s = 1'b1;
      OPC_FLW: begin
        rs1_use_s = 1'b1;
        rd_fp_s   = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
        no_rd_s   = 1'b1;
      end
      OPC_FSW: begin
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
        rs2_fp_s  = 1'b1;
        no_rd_s   = 1'b1;
      end
      OPC_OP: begin
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
      end
      OPC_FP: begin
        rs1_use_s = 1'b1;
        rs1_fp_s  = !((f7_s == 7'b1101000) || (f7_s == 7'b1111000));
        // fsqrt and the convert/move/class group carry no rs2 register
        rs2_use_s = (!f7_s[6] && (f7_s != 7'b0101100)) || (f7_s == 7'b1010000);
        rs2_fp_s  = 1'b1;
        rd_fp_s   = !((f7_s == 7'b1100000) || (f7_s == 7'b1110000) || (f7_s == 7'b1010000));
      end
      default: no_rd_s = 1'b0;
    endcase
    rs1_fp_s = rs1_fp_s && FP_EN;
    rs2_fp_s = rs2_fp_s && FP_EN;
    rd_fp_s  = rd_fp_s && FP_EN;
    rd_we_s  = !no_rd_s && (rd_fp_s || (rd_s != '0));
  end

  assign byp1_s = wb_valid && (wb_fp == rs1_fp_s) && (wb_rd == rs1_s) && (rs1_fp_s || (rs1_s != '0));
  assign byp2_s = wb_valid && (wb_fp == rs2_fp_s) && (wb_rd == rs2_s) && (rs2_fp_s || (rs2_s != '0));
  assign rs1_data_s = byp1_s ? wb_data : (rs1_fp_s ? fpr_q[rs1_s] : gpr_q[rs1_s]);
  assign rs2_data_s = byp2_s ? wb_data : (rs2_fp_s ? fpr_q[rs2_s] : gpr_q[rs2_s]);

  // Scoreboard: writeback clears, flush drops the held rd, acceptance sets (set wins)
  always_comb begin
    gpr_clr_s  = '0;
    fpr_clr_s  = '0;
    gpr_set_s  = '0;
    fpr_set_s  = '0;
    gpr_drop_s = '0;
    fpr_drop_s = '0;
    gpr_clr_s[wb_rd]     = wb_valid && !wb_fp;
    fpr_clr_s[wb_rd]     = wb_valid && wb_fp && FP_EN;
    gpr_set_s[rd_s]      = accept_s && rd_we_s && !rd_fp_s;
    fpr_set_s[rd_s]      = accept_s && rd_we_s && rd_fp_s;
    gpr_drop_s[out_rd_s] = flush && out_valid_q && out_rd_we_q && !out_rd_fp_q;
    fpr_drop_s[out_rd_s] = flush && out_valid_q && out_rd_we_q && out_rd_fp_q;
    gpr_busy_s = gpr_pend_q & ~gpr_clr_s;
    fpr_busy_s = fpr_pend_q & ~fpr_clr_s;
    gpr_pend_d = (gpr_busy_s & ~gpr_drop_s) | gpr_set_s;
    fpr_pend_d = (fpr_busy_s & ~fpr_drop_s) | fpr_set_s;
  end

  assign haz_s = (rs1_use_s && (rs1_fp_s ? fpr_busy_s[rs1_s] : gpr_busy_s[rs1_s])) ||
                 (rs2_use_s && (rs2_fp_s ? fpr_busy_s[rs2_s] : gpr_busy_s[rs2_s])) ||
                 (rd_we_s   && (rd_fp_s  ? fpr_busy_s[rd_s]  : gpr_busy_s[rd_s]));
  assign in_ready = (!out_valid_q || out_ready) && !haz_s && !flush;
  assign accept_s = in_valid && in_ready;
  assign stall_d  = (in_valid && haz_s && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

  // Output stage next state
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_rd_fp_d = out_rd_fp_q;
    out_rd_we_d = out_rd_we_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      out_instr_d = instruction;
      out_rs1_d   = rs1_data_s;
      out_rs2_d   = rs2_data_s;
      out_rd_fp_d = rd_fp_s;
      out_rd_we_d = rd_we_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Register files; x0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_q <= '0;
      fpr_q <= '0;
    end else begin
      if (wb_valid && !wb_fp && (wb_rd != '0)) gpr_q[wb_rd] <= wb_data;
      if (wb_valid && wb_fp && FP_EN) fpr_q[wb_rd] <= wb_data;
    end
  end

  // Pipeline, scoreboard and stall counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_pend_q  <= '0;
      fpr_pend_q  <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_fp_q <= 1'b0;
      out_rd_we_q <= 1'b0;
      stall_q     <= 16'd0;
    end else begin
      gpr_pend_q  <= gpr_pend_d;
      fpr_pend_q  <= fpr_pend_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_rd_fp_q <= out_rd_fp_d;
      out_rd_we_q <= out_rd_we_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_rs1_data = out_rs1_q;
  assign out_rs2_data = out_rs2_q;
  assign out_rd_fp    = out_rd_fp_q;
  assign out_rd_we    = out_rd_we_q;
  assign stall_cnt    = stall_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios then random traffic, all checked
// against a transaction-level model of the register files, scoreboard and output stage.
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_valid, wb_fp, flush;
  logic        out_valid, out_ready, out_rd_fp, out_rd_we;
  logic [31:0] instruction, wb_data, out_instr, out_rs1_data, out_rs2_data;
  logic [4:0]  wb_rd;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_fpr [32];
  bit          m_gp [32];
  bit          m_fp [32];
  bit          m_ov, m_rdfp, m_rdwe;
  logic [31:0] m_instr, m_rs1, m_rs2;
  int          m_stall;

  localparam logic [6:0] OP = 7'h33;
  localparam logic [6:0] OPFP = 7'h53;

  decode_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .wb_valid(wb_valid), .wb_fp(wb_fp),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_rd_fp(out_rd_fp), .out_rd_we(out_rd_we),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input int rs2, input int rs1,
                                        input int rd, input logic [6:0] op);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), op};
  endfunction

  // Instruction classes straight from the ISA operand rules
  function automatic void classify(input logic [31:0] ins, output bit u1, output bit u2,
                                   output bit f1, output bit f2, output bit fd, output bit we);
    logic [6:0] op = ins[6:0];
    logic [6:0] f7 = ins[31:25];
    bit         isfp = (op == OPFP);
    bit         nowr = op inside {7'h23, 7'h27, 7'h63};
    u1 = op inside {7'h03, 7'h07, 7'h13, 7'h23, 7'h27, 7'h33, 7'h53, 7'h63, 7'h67};
    u2 = (op inside {7'h23, 7'h27, 7'h33, 7'h63}) ||
         (isfp && (f7 inside {7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h14, 7'h50}));
    f1 = isfp && !(f7 inside {7'h68, 7'h78});
    f2 = isfp || (op == 7'h27);
    fd = (op == 7'h07) || (isfp && !(f7 inside {7'h60, 7'h70, 7'h50}));
    we = !nowr && (fd || (ins[11:7] != 5'd0));
  endfunction

  function automatic bit busy(input bit fp, input logic [4:0] idx);
    bit p = fp ? m_fp[idx] : m_gp[idx];
    return p && !(wb_valid && (wb_fp == fp) && (wb_rd == idx));
  endfunction

  function automatic bit model_hazard();
    bit u1, u2, f1, f2, fd, we;
    classify(instruction, u1, u2, f1, f2, fd, we);
    return (u1 && busy(f1, instruction[19:15])) || (u2 && busy(f2, instruction[24:20])) ||
           (we && busy(fd, instruction[11:7]));
  endfunction

  function automatic bit model_ready();
    return (!m_ov || out_ready) && !model_hazard() && !flush;
  endfunction

  function automatic logic [31:0] read_reg(input bit fp, input logic [4:0] idx);
    if (wb_valid && (wb_fp == fp) && (wb_rd == idx) && (fp || (idx != 5'd0))) return wb_data;
    return fp ? m_fpr[idx] : m_gpr[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = 32'd0; m_fpr[i] = 32'd0; m_gp[i] = 1'b0; m_fp[i] = 1'b0;
    end
    m_ov = 1'b0; m_rdfp = 1'b0; m_rdwe = 1'b0;
    m_instr = 32'd0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_stall = 0;
  endtask

  // One clock of the model, using the inputs held across the edge
  task automatic model_step();
    bit u1, u2, f1, f2, fd, we, haz, acc;
    logic [31:0] a, b;
    logic [4:0] rd;
    if (rst) begin
      model_reset();
      return;
    end
    classify(instruction, u1, u2, f1, f2, fd, we);
    haz = model_hazard();
    acc = in_valid && model_ready();
    a = read_reg(f1, instruction[19:15]);
    b = read_reg(f2, instruction[24:20]);
    if (in_valid && haz && (m_stall < 65535)) m_stall++;
    if (wb_valid && wb_fp) begin
      m_fpr[wb_rd] = wb_data; m_fp[wb_rd] = 1'b0;
    end else if (wb_valid && (wb_rd != 5'd0)) begin
      m_gpr[wb_rd] = wb_data; m_gp[wb_rd] = 1'b0;
    end
    if (flush && m_ov && m_rdwe) begin
      rd = m_instr[11:7];
      if (m_rdfp) m_fp[rd] = 1'b0; else m_gp[rd] = 1'b0;
    end
    if (flush) m_ov = 1'b0;
    else if (acc) begin
      m_ov = 1'b1; m_instr = instruction; m_rs1 = a; m_rs2 = b; m_rdfp = fd; m_rdwe = we;
      rd = instruction[11:7];
      if (we && fd) m_fp[rd] = 1'b1;
      if (we && !fd) m_gp[rd] = 1'b1;
    end else if (out_ready) m_ov = 1'b0;
  endtask

  task automatic tick();
    #1;
    check("in_ready", 32'(in_ready), 32'(model_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_instr", out_instr, m_instr);
    check("out_rs1", out_rs1_data, m_rs1);
    check("out_rs2", out_rs2_data, m_rs2);
    check("out_rd_fp", 32'(out_rd_fp), 32'(m_rdfp));
    check("out_rd_we", 32'(out_rd_we), 32'(m_rdwe));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic set_idle();
    rst = 1'b0; in_valid = 1'b0; instruction = 32'd0; wb_valid = 1'b0; wb_fp = 1'b0;
    wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_wb(input bit fp, input int rd, input logic [31:0] d);
    set_idle(); wb_valid = 1'b1; wb_fp = fp; wb_rd = 5'(rd); wb_data = d; tick(); set_idle();
  endtask

  task automatic issue(input logic [31:0] ins);
    set_idle(); in_valid = 1'b1; instruction = ins; tick(); set_idle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    if ($urandom_range(0, 9) == 0) return r;
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'h03;  1: r[6:0] = 7'h07;  2: r[6:0] = 7'h13;  3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h27;  5: r[6:0] = 7'h33;  6: r[6:0] = 7'h53;  7: r[6:0] = 7'h63;
      8: r[6:0] = 7'h67;  9: r[6:0] = 7'h37;  default: r[6:0] = 7'h6F;
    endcase
    if (r[6:0] == OPFP) begin
      case ($urandom_range(0, 7))
        0: r[31:25] = 7'h00;  1: r[31:25] = 7'h08;  2: r[31:25] = 7'h2C;  3: r[31:25] = 7'h50;
        4: r[31:25] = 7'h60;  5: r[31:25] = 7'h68;  6: r[31:25] = 7'h70;  default: r[31:25] = 7'h78;
      endcase
    end
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);

    do_wb(1'b0, 5, 32'h0000_1234);
    issue(rtype(7'h00, 0, 5, 6, OP));
    check("wb_then_read", out_rs1_data, 32'h0000_1234);
    check("accept_latency", 32'(out_valid), 32'd1);
    do_wb(1'b0, 6, 32'h0000_0055);

    set_idle(); wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_FFFF;
    in_valid = 1'b1; instruction = rtype(7'h00, 0, 0, 10, OP); tick(); set_idle();
    check("x0_read", out_rs1_data, 32'd0);

    issue(rtype(7'h01, 2, 1, 7, OP));
    in_valid = 1'b1; instruction = rtype(7'h00, 1, 7, 8, OP);
    repeat (3) tick();
    check("raw_stall_cnt", 32'(stall_cnt), 32'd3);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'd9;
    #1 check("raw_release", 32'(in_ready), 32'd1);
    tick(); set_idle();
    check("raw_bypass", out_rs1_data, 32'd9);
    do_wb(1'b0, 8, 32'd1);

    do_wb(1'b1, 1, 32'h3F80_0000);
    issue(rtype(7'h00, 2, 1, 3, OPFP));
    check("fadd_rs1", out_rs1_data, 32'h3F80_0000);
    check("fadd_rd_fp", 32'(out_rd_fp), 32'd1);
    do_wb(1'b1, 3, 32'h4040_0000);
    issue(rtype(7'h70, 0, 3, 9, OPFP));
    check("fmvxw_rd_fp", 32'(out_rd_fp), 32'd0);
    check("fmvxw_rs1", out_rs1_data, 32'h4040_0000);
    do_wb(1'b0, 9, 32'd2);

    in_valid = 1'b1; out_ready = 1'b0; instruction = rtype(7'h00, 2, 1, 11, OP); tick();
    instruction = rtype(7'h00, 2, 1, 12, OP);
    repeat (3) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_instr", out_instr, rtype(7'h00, 2, 1, 11, OP));
    end
    set_idle(); flush = 1'b1; tick(); set_idle();
    check("flush_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; instruction = rtype(7'h00, 0, 11, 13, OP);
    #1 check("flush_unpend", 32'(in_ready), 32'd1);
    tick(); set_idle();

    issue(rtype(7'h01, 2, 1, 7, OP));
    in_valid = 1'b1; instruction = rtype(7'h00, 1, 7, 8, OP);
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_stall", 32'(stall_cnt), 32'd0);
    check("rst_mid_instr", out_instr, 32'd0);
    #1 check("rst_mid_ready", 32'(in_ready), 32'd1);
    tick(); set_idle();
    check("rst_regs_cleared", out_rs1_data, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      set_idle();
      rst         = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_valid    = ($urandom_range(0, 2) != 0);
      instruction = rand_instr();
      wb_valid    = 1'($urandom_range(0, 1));
      wb_fp       = 1'($urandom_range(0, 1));
      wb_rd       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_data     = $urandom();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
